// File: rtl/lif_neuron_core.sv
// lif_neuron_core: one leaky integrate-and-fire neuron with N_IN serial synapses.
//
// Each accepted start runs one timestep: LEAK (v -= v >>> LEAK_SHIFT), ACCUM (one synapse per
// clock, saturating add of the weight when the latched spike bit is set and the neuron is not
// refractory), then FIRE (threshold compare or refractory countdown). Start-to-done latency is
// N_IN+2 cycles.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   wr_en/addr/data   - weight register write, honoured only while idle
//   threshold         - signed firing threshold, sampled in FIRE
//   start, spikes     - begin a timestep; spikes latched on an accepted start
//   busy              - timestep in progress
//   done, spike_out   - one-cycle completion pulse and fire flag
//   v_mem             - registered signed membrane potential
//   refrac_active     - refractory counter nonzero
module lif_neuron_core #(
    parameter int unsigned N_IN       = 8,
    parameter int unsigned W_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned LEAK_SHIFT = 4,
    parameter int unsigned REFRAC     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(N_IN)-1:0]   wr_addr,
    input  logic [W_WIDTH-1:0]        wr_data,
    input  logic [ACC_WIDTH-1:0]      threshold,
    input  logic                      start,
    input  logic [N_IN-1:0]           spikes,
    output logic                      busy,
    output logic                      done,
    output logic                      spike_out,
    output logic [ACC_WIDTH-1:0]      v_mem,
    output logic                      refrac_active
);

    localparam int unsigned IdxW = $clog2(N_IN);
    localparam int unsigned CntW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    typedef enum logic [1:0] {StIdle, StLeak, StAccum, StFire} state_e;

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] v_q, v_d;
    logic [N_IN-1:0]             spk_q, spk_d;
    logic [IdxW-1:0]             idx_q, idx_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        done_q, done_d;
    logic                        fire_q, fire_d;
    logic [W_WIDTH-1:0]          w_q [N_IN];

    logic signed [ACC_WIDTH-1:0] leak_v;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH-1:0] sat_v;
    logic [W_WIDTH-1:0]          w_cur;

    // Leak never overflows: subtracting floor(v / 2^LEAK_SHIFT) moves v toward zero.
    assign leak_v = v_q - (v_q >>> LEAK_SHIFT);
    assign w_cur  = w_q[idx_q];
    assign sum    = {v_q[ACC_WIDTH-1], v_q}
                  + {{(ACC_WIDTH + 1 - W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};

    // Overflow when the extra sign bit disagrees with the result sign bit.
    always_comb begin
        sat_v = sum[ACC_WIDTH-1:0];
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            sat_v = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        spk_d   = spk_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        fire_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    spk_d   = spikes;
                    idx_d   = '0;
                    state_d = StLeak;
                end
            end
            StLeak: begin
                v_d     = leak_v;
                state_d = StAccum;
            end
            StAccum: begin
                if (spk_q[idx_q] && (cnt_q == '0)) begin
                    v_d = sat_v;
                end
                if (idx_q == IdxW'(N_IN - 1)) begin
                    state_d = StFire;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StFire: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (v_q >= $signed(threshold)) begin
                    fire_d = 1'b1;
                    v_d    = '0;
                    cnt_d  = CntW'(REFRAC);
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            v_q     <= '0;
            spk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            spk_q   <= spk_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fire_q  <= fire_d;
        end
    end

    // Weights are only writable between timesteps so a run sees a stable weight set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
            end
        end else if (wr_en && (state_q == StIdle)) begin
            w_q[wr_addr] <= wr_data;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign spike_out     = fire_q;
    assign v_mem         = v_q;
    assign refrac_active = (cnt_q != '0);

endmodule
